serial_cla_alu: RTL and testbench
=================================

# serial_cla_alu

Digit-serial, parametrised add/subtract unit with status flags, the multi-cycle successor to the team's 16-bit combinational lookahead ALU. Each clock it processes one DIGIT-bit lookahead group, LSB group first, and chains the carry through a register. It supports add, subtract and carry-chained variants, and uses a start/busy/done handshake. It sits beside the datapath wherever a wide operand must be summed with a small, fixed adder footprint.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per cycle (lookahead group width).
- PARITY_ODD, 1, 1: parity = XNOR-reduce of z; 0: parity = XOR-reduce of z.
- Derived: N = WIDTH/DIGIT, the number of digit cycles.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when the unit is idle or done.
- op  in  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- cin  in  1  carry/borrow input, used by ADC and SBB only.
- x  in  WIDTH  operand A, latched when start is accepted.
- y  in  WIDTH  operand B, latched when start is accepted.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse; z and flags are valid and new.
- z  out  WIDTH  result register.
- sign  out  1  z[WIDTH-1].
- zero  out  1  z == 0.
- parity  out  1  see PARITY_ODD.
- carry  out  1  carry out of the MSB. For SUB/SBB this is not-borrow.
- overflow  out  1  signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE & start: accept the request.
  - Latch x.
  - Latch the effective y: y for ADD/ADC, ~y for SUB/SBB.
  - Set the chained carry c0: ADD 0, SUB 1, ADC cin, SBB ~cin (so SBB computes x - y - cin).
  - Clear the digit counter k and go to RUN.
- IDLE/DONE & no start: go to IDLE (DONE always lasts exactly one cycle).
- RUN, each cycle:
  - Add digit k of x and effective y with the carry register.
  - Write sum bits [k*DIGIT +: DIGIT] into z; store the group carry-out in the carry register.
  - Increment k.
- RUN, on the cycle with k = N-1:
  - Register the flags, computed from the completed z value being written.
  - overflow = xa&ya&~zm | ~xa&~ya&zm, where xa, ya, zm are the MSBs of x, effective y and z.
  - carry is the final group carry-out. Go to DONE.
- start while in RUN is ignored; it is neither queued nor allowed to disturb operands.
- z and the flags change only at digit writes; they hold their value from DONE until the next completion. Partial z is visible during RUN.
- Reset, asynchronous, at any time including mid-RUN:
  - state IDLE, k=0, carry register 0.
  - z=0, sign=0, zero=0, parity=0, carry=0, overflow=0.
  - busy=0, done=0.
  - No done is produced for an aborted operation.

## Timing
- Latency: done is high in the cycle that begins N rising edges after the edge that sampled start. For WIDTH=16, DIGIT=4 that is 4 edges.
- busy is high for exactly N cycles per operation and low in IDLE and DONE.
- Back-to-back: a start accepted in the DONE cycle begins RUN on the next edge. Throughput is one result per N+1 cycles with no idle gap.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package alu_pkg:
  - op encodings OP_ADD, OP_SUB, OP_ADC, OP_SBB;
  - state encoding ST_IDLE, ST_RUN, ST_DONE.
- Sub-module cla_group, parametrised by DIGIT and purely combinational:
  - per-bit generate/propagate;
  - lookahead carries;
  - DIGIT-bit sum and group carry-out.
- Top level holds: FSM, digit counter (clog2(N) bits), operand registers, carry register, z/flag registers.

## Test plan
- ADD 0x7FFF + 0x0001 -> z=0x8000, sign=1, overflow=1, carry=0, zero=0, parity=0; done exactly 4 edges after start, busy high for 4 cycles.
- SUB 0x1234 - 0x1234 -> z=0x0000, zero=1, carry=1, overflow=0, parity=1.
- ADD 0xFFFF + 0x0001 -> z=0x0000, carry=1, zero=1, overflow=0.
- SBB with x=0x0000, y=0x0000, cin=1 -> z=0xFFFF, carry=0, sign=1, parity=1, overflow=0.
- Handshake and reset:
  - start pulsed mid-RUN -> ignored; result matches the first operands.
  - start held in the DONE cycle -> second result arrives 4 edges later.
  - rst asserted after 2 RUN cycles -> all outputs 0 immediately, no done.
- WIDTH=32, DIGIT=8: ADD 0x89ABCDEF + 0x76543211 -> z=0x00000000, carry=1, zero=1, done 4 edges after start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the digit-serial lookahead add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // Operation select
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cla_group.sv
// One DIGIT-bit carry-lookahead adder group.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b - group operands; ci - carry in; s - group sum; co - group carry out.
module cla_group #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT-1:0] g;
  logic [DIGIT-1:0] p;
  logic [DIGIT:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded into flat sum-of-products form so no carry
  // depends on the previous one:
  //   c[i+1] = ci&p[0..i] | g[0]&p[1..i] | ... | g[i]
  always_comb begin
    logic term;
    logic cy;
    c    = '0;
    term = 1'b0;
    cy   = 1'b0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      term = ci;
      for (int m = 0; m <= i; m++) term = term & p[m];
      cy = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        cy = cy | term;
      end
      c[i+1] = cy;
    end
  end

  assign s  = p ^ c[DIGIT-1:0];
  assign co = c[DIGIT];

endmodule

// File: rtl/serial_cla_alu.sv
// Digit-serial add/subtract unit: one DIGIT-bit lookahead group per cycle, LSB first, with status flags.
// Latency: done pulses N=WIDTH/DIGIT edges after the edge that accepts start; one result per N+1 cycles.
// Backpressure: start is taken only in IDLE or DONE; a start during RUN is dropped, never queued.
// Ports: clk, rst (async, active high); start/op/cin/x/y request; busy/done status;
//        z result; sign/zero/parity/carry/overflow flags registered at completion.
import alu_pkg::*;

module serial_cla_alu #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int PARITY_ODD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             sign,
  output logic             zero,
  output logic             parity,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] x_q, y_q;   // y_q holds the effective (possibly inverted) operand
  logic             c_q;
  logic             accept, last;
  logic             y_inv, c0;
  logic [DIGIT-1:0] xd, yd, sd;
  logic             co;
  logic [WIDTH-1:0] z_next;

  // ---------------- controller ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_RUN);
      done    <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (k_q == KW'(N - 1)) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- request decode ----------------
  always_comb begin
    y_inv = (op == OP_SUB) || (op == OP_SBB);
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      OP_ADC:  c0 = cin;
      default: c0 = ~cin;   // SBB: x + ~y + ~cin == x - y - cin
    endcase
  end

  // ---------------- digit datapath ----------------
  always_comb begin
    xd = '0;
    yd = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        xd = x_q[i*DIGIT +: DIGIT];
        yd = y_q[i*DIGIT +: DIGIT];
      end
    end
  end

  cla_group #(.DIGIT(DIGIT)) u_grp (
    .a  (xd),
    .b  (yd),
    .ci (c_q),
    .s  (sd),
    .co (co)
  );

  // z with the current digit merged in; on the last digit this is the
  // completed result the flags are derived from.
  always_comb begin
    z_next = z;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) z_next[i*DIGIT +: DIGIT] = sd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      c_q      <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      z        <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      parity   <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      x_q <= x;
      y_q <= y_inv ? ~y : y;
      c_q <= c0;
      k_q <= '0;
    end else if (state_q == ST_RUN) begin
      z   <= z_next;
      c_q <= co;
      k_q <= k_q + KW'(1);
      if (last) begin
        sign     <= z_next[WIDTH-1];
        zero     <= (z_next == '0);
        parity   <= (PARITY_ODD != 0) ? ~^z_next : ^z_next;
        carry    <= co;
        // On the last digit xd/yd/sd carry the operand and result MSBs.
        overflow <= (xd[DIGIT-1] & yd[DIGIT-1] & ~sd[DIGIT-1]) |
                    (~xd[DIGIT-1] & ~yd[DIGIT-1] & sd[DIGIT-1]);
      end
    end
  end

endmodule

// File: tb/tb_serial_cla_alu.sv
module tb_serial_cla_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // 16-bit / 4-bit-digit instance
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        cin = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        busy, done;
  logic [15:0] z;
  logic        sign, zero, parity, carry, overflow;

  // 32-bit / 8-bit-digit instance
  logic        start2 = 1'b0;
  logic [1:0]  op2 = 2'b00;
  logic        cin2 = 1'b0;
  logic [31:0] x2 = '0, y2 = '0;
  logic        busy2, done2;
  logic [31:0] z2;
  logic        sign2, zero2, parity2, carry2, overflow2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_cla_alu #(.WIDTH(16), .DIGIT(4), .PARITY_ODD(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .x(x), .y(y),
    .busy(busy), .done(done), .z(z), .sign(sign), .zero(zero),
    .parity(parity), .carry(carry), .overflow(overflow)
  );

  serial_cla_alu #(.WIDTH(32), .DIGIT(8), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(op2), .cin(cin2), .x(x2), .y(y2),
    .busy(busy2), .done(done2), .z(z2), .sign(sign2), .zero(zero2),
    .parity(parity2), .carry(carry2), .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [1:0] o, input logic c, input logic [15:0] a, input logic [15:0] b);
    op = o; cin = c; x = a; y = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Counts edges until done is seen (sampled at negedges), and busy cycles on the way.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (lat < 20) begin
      if (busy) bcnt++;
      if (done) break;
      @(posedge clk); lat++;
      @(negedge clk);
    end
  endtask

  int lat, bcnt, seen;

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("rst z", z, 16'h0000);
    chk("rst flags", {sign, zero, parity, carry, overflow}, 5'b00000);
    chk("rst busy/done", {busy, done}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // ADD 0x7FFF + 0x0001
    issue(2'b00, 1'b0, 16'h7FFF, 16'h0001);
    wait_done(lat, bcnt);
    chk("add1 latency", lat, 4);
    chk("add1 busy cycles", bcnt, 4);
    chk("add1 z", z, 16'h8000);
    chk("add1 flags", {sign, zero, parity, carry, overflow}, 5'b10001);
    @(negedge clk);
    chk("add1 done one cycle", {busy, done}, 2'b00);
    chk("add1 z held", z, 16'h8000);

    // SUB 0x1234 - 0x1234
    issue(2'b01, 1'b0, 16'h1234, 16'h1234);
    wait_done(lat, bcnt);
    chk("sub z", z, 16'h0000);
    chk("sub flags", {sign, zero, parity, carry, overflow}, 5'b01110);
    @(negedge clk);

    // ADD 0xFFFF + 0x0001
    issue(2'b00, 1'b0, 16'hFFFF, 16'h0001);
    wait_done(lat, bcnt);
    chk("add2 z", z, 16'h0000);
    chk("add2 flags", {sign, zero, parity, carry, overflow}, 5'b01110);
    @(negedge clk);

    // SBB 0 - 0 - 1
    issue(2'b11, 1'b1, 16'h0000, 16'h0000);
    wait_done(lat, bcnt);
    chk("sbb z", z, 16'hFFFF);
    chk("sbb flags", {sign, zero, parity, carry, overflow}, 5'b10100);
    @(negedge clk);

    // ADC 0xFFFF + 0xFFFF + 1 = 0x1FFFF
    issue(2'b10, 1'b1, 16'hFFFF, 16'hFFFF);
    wait_done(lat, bcnt);
    chk("adc z", z, 16'hFFFF);
    chk("adc flags", {sign, zero, parity, carry, overflow}, 5'b10110);
    @(negedge clk);

    // start pulsed mid-RUN must be ignored
    issue(2'b00, 1'b0, 16'h0102, 16'h0304);
    op = 2'b01; x = 16'hFFFF; y = 16'h0001; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; op = 2'b00; x = '0; y = '0;
    @(negedge clk);
    wait_done(lat, bcnt);
    chk("midrun latency", lat, 3);
    chk("midrun z", z, 16'h0406);
    chk("midrun flags", {sign, zero, parity, carry, overflow}, 5'b00000);
    @(negedge clk);

    // back-to-back: start held in the DONE cycle
    issue(2'b00, 1'b0, 16'h0001, 16'h0002);
    wait_done(lat, bcnt);
    chk("b2b first z", z, 16'h0003);
    issue(2'b00, 1'b0, 16'h0010, 16'h0020);
    chk("b2b busy after accept", busy, 1'b1);
    wait_done(lat, bcnt);
    chk("b2b second latency", lat, 4);
    chk("b2b second z", z, 16'h0030);
    @(negedge clk);

    // reset after two RUN cycles
    issue(2'b00, 1'b0, 16'h7FFF, 16'h0001);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort z", z, 16'h0000);
    chk("abort flags", {sign, zero, parity, carry, overflow}, 5'b00000);
    chk("abort busy/done", {busy, done}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("abort no done", seen, 0);

    // 32-bit / 8-bit digits
    op2 = 2'b00; cin2 = 1'b0; x2 = 32'h89ABCDEF; y2 = 32'h76543211; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    @(negedge clk);
    lat = 0;
    while (lat < 20 && !done2) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("w32 latency", lat, 4);
    chk("w32 z", z2, 32'h00000000);
    chk("w32 flags", {sign2, zero2, parity2, carry2, overflow2}, 5'b01110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
